// File: rtl/neko_mem_pkg.sv
// Shared types and constants for the LSU memory bridge: FSM encoding,
// GM/LDS select values, tag width and the timeout poison word.
package neko_mem_pkg;

  localparam int unsigned TAG_W  = 7;
  localparam int unsigned ADDR_W = 32;

  localparam logic SEL_GM  = 1'b1;
  localparam logic SEL_LDS = 1'b0;

  localparam logic [31:0] POISON = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LDS_ACC = 3'd1,
    ST_GM_REQ  = 3'd2,
    ST_GM_WAIT = 3'd3,
    ST_ACK     = 3'd4
  } mem_state_e;

  // Latched request; the GM/LDS choice lives in the state itself.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-3:0] waddr;
    logic [TAG_W-1:0]  tag;
  } mem_req_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-3:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/neko_lds_ram.sv
// Single-port synchronous LDS RAM, one-cycle read latency, read-first on write.
module neko_lds_ram #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/neko_lsu_mem_bridge.sv
// Bridges single-word LSU requests to the LDS RAM or the global-memory port.
// Optional GM watchdog enabled by defining NEKO_MEM_BRIDGE_TIMEOUT_EN.
module neko_lsu_mem_bridge
  import neko_mem_pkg::*;
#(
  parameter int unsigned MEMORY_BUS_WIDTH  = 32,
  parameter int unsigned LDS_ADDR_WIDTH    = 12,
  parameter int unsigned GM_TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_rd_en,
  input  logic                        mem_wr_en,
  input  logic                        mem_gm_or_lds,
  input  logic [ADDR_W-1:0]           mem_addr,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_wr_data,
  input  logic [TAG_W-1:0]            mem_tag_req,
  output logic                        mem_ack,
  output logic [TAG_W-1:0]            mem_tag_resp,
  output logic [MEMORY_BUS_WIDTH-1:0] mem_rd_data,
  output logic                        gm_req_valid,
  input  logic                        gm_req_ready,
  output logic                        gm_req_we,
  output logic [ADDR_W-1:0]           gm_req_addr,
  output logic [MEMORY_BUS_WIDTH-1:0] gm_req_wdata,
  input  logic                        gm_resp_valid,
  input  logic [MEMORY_BUS_WIDTH-1:0] gm_resp_rdata,
  output logic                        bridge_busy,
  output logic                        bridge_overrun,
  output logic                        bridge_err
);

  localparam int unsigned DW = MEMORY_BUS_WIDTH;
  localparam int unsigned AW = LDS_ADDR_WIDTH;

  mem_state_e    r_state, w_next;
  mem_req_t      r_req;
  logic [DW-1:0] r_wdata;
  logic          r_ack;
  logic [TAG_W-1:0] r_tag_resp;
  logic [DW-1:0] r_rd_data;
  logic          r_gm_valid, r_busy, r_overrun, r_err;

  logic          w_req, w_accept, w_ram_en, w_timeout;
  logic          w_ack_load, w_to_fire;
  logic [DW-1:0] w_ack_data, w_ram_rdata;
  logic [1:0]    w_unused_addr_lsb;

  assign w_req             = mem_rd_en | mem_wr_en;
  assign w_accept          = (r_state == ST_IDLE) && w_req;
  assign w_unused_addr_lsb = mem_addr[1:0];

  // The RAM access is launched at capture so its data is ready during LDS_ACC.
  assign w_ram_en = w_accept && (mem_gm_or_lds == SEL_LDS);

  neko_lds_ram #(.AW(AW), .DW(DW)) u_lds_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (mem_wr_en),
    .i_addr  (mem_addr[AW+1:2]),
    .i_wdata (mem_wr_data),
    .o_rdata (w_ram_rdata)
  );

`ifdef NEKO_MEM_BRIDGE_TIMEOUT_EN
  localparam int unsigned TO_CLOG = $clog2(GM_TIMEOUT_CYCLES + 1);
  localparam int unsigned TO_W    = (TO_CLOG < 8) ? 8 : TO_CLOG;

  logic [TO_W-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                             r_to_cnt <= '0;
    else if (w_accept && (mem_gm_or_lds == SEL_GM))      r_to_cnt <= '0;
    else if ((r_state == ST_GM_REQ) || (r_state == ST_GM_WAIT)) r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_timeout = ((r_state == ST_GM_REQ) || (r_state == ST_GM_WAIT)) &&
                     (r_to_cnt >= TO_W'(GM_TIMEOUT_CYCLES));
`else
  assign w_timeout = (GM_TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next state plus the value the ACK-stage registers load on entry to ACK.
  always_comb begin
    w_next     = r_state;
    w_ack_load = 1'b0;
    w_ack_data = '0;
    w_to_fire  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = (mem_gm_or_lds == SEL_GM) ? ST_GM_REQ : ST_LDS_ACC;
      end
      ST_LDS_ACC: begin
        w_next     = ST_ACK;
        w_ack_load = 1'b1;
        w_ack_data = r_req.we ? '0 : w_ram_rdata;
      end
      ST_GM_REQ: begin
        if (gm_req_ready) begin
          w_next = ST_GM_WAIT;
        end else if (w_timeout) begin
          w_next     = ST_ACK;
          w_ack_load = 1'b1;
          w_ack_data = DW'(POISON);
          w_to_fire  = 1'b1;
        end
      end
      ST_GM_WAIT: begin
        if (gm_resp_valid) begin
          w_next     = ST_ACK;
          w_ack_load = 1'b1;
          w_ack_data = r_req.we ? '0 : gm_resp_rdata;
        end else if (w_timeout) begin
          w_next     = ST_ACK;
          w_ack_load = 1'b1;
          w_ack_data = DW'(POISON);
          w_to_fire  = 1'b1;
        end
      end
      ST_ACK:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req      <= '0;
      r_wdata    <= '0;
      r_ack      <= 1'b0;
      r_tag_resp <= '0;
      r_rd_data  <= '0;
      r_gm_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_req.we    <= mem_wr_en;
        r_req.waddr <= mem_addr[ADDR_W-1:2];
        r_req.tag   <= mem_tag_req;
        r_wdata     <= mem_wr_data;
      end
      r_ack      <= w_ack_load;
      r_tag_resp <= w_ack_load ? r_req.tag : '0;
      r_rd_data  <= w_ack_data;
      r_gm_valid <= (w_next == ST_GM_REQ);
      r_busy     <= (w_next != ST_IDLE);
      if (w_req && ((r_state != ST_IDLE) || (mem_rd_en && mem_wr_en))) r_overrun <= 1'b1;
      if (w_to_fire) r_err <= 1'b1;
    end
  end

  assign mem_ack        = r_ack;
  assign mem_tag_resp   = r_tag_resp;
  assign mem_rd_data    = r_rd_data;
  assign gm_req_valid   = r_gm_valid;
  assign gm_req_we      = r_req.we;
  assign gm_req_addr    = word_align(r_req.waddr);
  assign gm_req_wdata   = r_wdata;
  assign bridge_busy    = r_busy;
  assign bridge_overrun = r_overrun;
  assign bridge_err     = r_err;

endmodule

// File: tb/tb_neko_lsu_mem_bridge.sv
// Randomized self-checking bench for neko_lsu_mem_bridge against a
// transaction-level model (latency rules, LDS array, sticky flag windows).
module tb_neko_lsu_mem_bridge;

  localparam int T_TO = 16;
  localparam int BIG  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0, mem_gm_or_lds = 1'b0;
  logic [31:0] mem_addr = '0, mem_wr_data = '0;
  logic [6:0]  mem_tag_req = '0;
  logic        mem_ack;
  logic [6:0]  mem_tag_resp;
  logic [31:0] mem_rd_data;
  logic        gm_req_valid, gm_req_we;
  logic        gm_req_ready = 1'b0;
  logic [31:0] gm_req_addr, gm_req_wdata;
  logic        gm_resp_valid = 1'b0;
  logic [31:0] gm_resp_rdata = '0;
  logic        bridge_busy, bridge_overrun, bridge_err;

  neko_lsu_mem_bridge #(.MEMORY_BUS_WIDTH(32), .LDS_ADDR_WIDTH(12), .GM_TIMEOUT_CYCLES(T_TO)) dut (
    .clk(clk), .rst(rst),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_gm_or_lds(mem_gm_or_lds),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_tag_req(mem_tag_req),
    .mem_ack(mem_ack), .mem_tag_resp(mem_tag_resp), .mem_rd_data(mem_rd_data),
    .gm_req_valid(gm_req_valid), .gm_req_ready(gm_req_ready), .gm_req_we(gm_req_we),
    .gm_req_addr(gm_req_addr), .gm_req_wdata(gm_req_wdata),
    .gm_resp_valid(gm_resp_valid), .gm_resp_rdata(gm_resp_rdata),
    .bridge_busy(bridge_busy), .bridge_overrun(bridge_overrun), .bridge_err(bridge_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model expectations, expressed as cycle windows.
  int          exp_ack = -100, busy_s = 1, busy_e = 0, gv_s = 1, gv_e = 0;
  int          ovr_from = BIG, err_from = BIG;
  logic [6:0]  exp_tag = '0;
  logic [31:0] exp_data = '0, exp_gaddr = '0, exp_gwd = '0;
  logic        exp_gwe = 1'b0;
  logic [31:0] lds_m [4096];
  bit          lds_v [4096];

  int          n_acks = 0, last_ack_cyc = 0, last_req_cyc = 0;
  logic [31:0] last_ack_data = '0, last_gm_addr = '0;
  logic [6:0]  last_ack_tag = '0;
  bit          ack_e, gv_x;

  always @(negedge clk) begin
    ack_e = (cyc == exp_ack);
    chk("ack", 64'(mem_ack), 64'(ack_e));
    chk("tag_resp", 64'(mem_tag_resp), ack_e ? 64'(exp_tag) : 64'd0);
    chk("rd_data", 64'(mem_rd_data), ack_e ? 64'(exp_data) : 64'd0);
    if (mem_ack) begin
      n_acks++;
      last_ack_cyc  = cyc;
      last_ack_data = mem_rd_data;
      last_ack_tag  = mem_tag_resp;
    end
    chk("busy", 64'(bridge_busy), 64'(cyc >= busy_s && cyc <= busy_e));
    gv_x = (cyc >= gv_s && cyc <= gv_e);
    chk("gm_req_valid", 64'(gm_req_valid), 64'(gv_x));
    if (gv_x) begin
      chk("gm_req_addr", 64'(gm_req_addr), 64'(exp_gaddr));
      chk("gm_req_we", 64'(gm_req_we), 64'(exp_gwe));
      chk("gm_req_wdata", 64'(gm_req_wdata), 64'(exp_gwd));
      last_gm_addr = gm_req_addr;
    end
    chk("overrun", 64'(bridge_overrun), 64'(cyc >= ovr_from));
    chk("err", 64'(bridge_err), 64'(cyc >= err_from));
  end

  // One transaction. rdy_dly<0: never ready; rsp_dly<0: never respond (timeout);
  // spur: extra request in the first GM_WAIT cycle; rst_w: async reset in GM_WAIT.
  task automatic do_req(input bit rd, input bit wr, input bit gm, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [6:0] tag, input int rdy_dly,
                        input int rsp_dly, input logic [31:0] rsp_data, input bit spur,
                        input bit rst_w);
    int n, g, h, r, ack_c, end_c;
    logic [11:0] idx;
    @(posedge clk); #1;
    n = cyc; last_req_cyc = n;
    mem_rd_en = rd; mem_wr_en = wr; mem_gm_or_lds = gm;
    mem_addr = addr; mem_wr_data = wd; mem_tag_req = tag;
    if (rd && wr && (n + 1 < ovr_from)) ovr_from = n + 1;
    busy_s = n + 1;
    exp_tag = tag;
    if (!gm) begin
      idx = addr[13:2];
      if (wr) begin lds_m[idx] = wd; lds_v[idx] = 1'b1; exp_data = '0; end
      else exp_data = lds_m[idx];
      exp_ack = n + 2; busy_e = n + 2;
      @(posedge clk); #1;
      mem_rd_en = 1'b0; mem_wr_en = 1'b0;
      @(posedge clk); #1;
    end else begin
      g = n + 1;
      h = (rdy_dly < 0) ? BIG : g + rdy_dly;
      r = -1;
      if (rst_w) begin
        ack_c = -100; gv_e = h; end_c = h + 1;
      end else if (rsp_dly < 0) begin
        ack_c = g + T_TO + 1; gv_e = (rdy_dly < 0) ? g + T_TO : h;
        exp_data = 32'hDEADBEEF; end_c = ack_c + 1;
        if (ack_c < err_from) err_from = ack_c;
      end else begin
        r = h + rsp_dly; ack_c = r + 1; gv_e = h;
        exp_data = wr ? 32'h0 : rsp_data; end_c = ack_c;
      end
      busy_e = rst_w ? h : ack_c;
      gv_s = g; exp_gaddr = {addr[31:2], 2'b00}; exp_gwe = wr; exp_gwd = wd;
      exp_ack = ack_c;
      for (int c = n + 1; c <= end_c; c++) begin
        @(posedge clk); #1;
        mem_rd_en = spur && (c == h + 1); mem_wr_en = 1'b0;
        if (spur && c == h + 1) begin
          mem_tag_req = 7'($urandom);
          if (c + 1 < ovr_from) ovr_from = c + 1;
        end
        gm_req_ready  = (c == h) || (c > h && $urandom_range(0, 1) == 1);
        gm_resp_valid = (c == r) || (c < h && $urandom_range(0, 3) == 0) ||
                        (rsp_dly < 0 && !rst_w && c == end_c);
        gm_resp_rdata = (c == r) ? rsp_data : $urandom;
        if (rst_w && c == h + 1) begin
          #2; rst = 1'b1; ovr_from = BIG; err_from = BIG;
          #1;
          chk("rst_async_ctrl", 64'({mem_ack, mem_tag_resp, mem_rd_data, gm_req_valid, gm_req_we,
              bridge_busy, bridge_overrun, bridge_err}), 64'd0);
          chk("rst_async_gaddr", 64'(gm_req_addr), 64'd0);
          chk("rst_async_gwdata", 64'(gm_req_wdata), 64'd0);
        end
      end
      gm_req_ready = 1'b0; gm_resp_valid = 1'b0; mem_rd_en = 1'b0;
      if (rst_w) begin @(posedge clk); #1; rst = 1'b0; end
    end
    @(negedge clk); #1;
  endtask

  int          k, a0, rd_i, rsp_i;
  bit          rb, wb;
  logic [11:0] ridx;
  logic [31:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({mem_ack, mem_tag_resp, mem_rd_data, gm_req_valid, bridge_busy,
        bridge_overrun, bridge_err}), 64'd0);
    rst = 1'b0;

    do_req(0, 1, 0, 32'h40, 32'h12345678, 7'd5, 0, 0, 0, 0, 0);
    chk("lds_wr_data", 64'(last_ack_data), 64'h0);
    chk("lds_wr_tag", 64'(last_ack_tag), 64'd5);
    chk("lds_wr_latency", 64'(last_ack_cyc - last_req_cyc), 64'd2);
    do_req(1, 0, 0, 32'h40, 32'h0, 7'd6, 0, 0, 0, 0, 0);
    chk("lds_rd_data", 64'(last_ack_data), 64'h12345678);
    chk("lds_rd_tag", 64'(last_ack_tag), 64'd6);
    chk("lds_rd_latency", 64'(last_ack_cyc - last_req_cyc), 64'd2);

    do_req(0, 1, 0, 32'h4000_0040, 32'hA5A50F0F, 7'd1, 0, 0, 0, 0, 0);
    do_req(1, 0, 0, 32'h40, 32'h0, 7'd2, 0, 0, 0, 0, 0);
    chk("lds_wrap_data", 64'(last_ack_data), 64'hA5A50F0F);

    do_req(1, 0, 1, 32'h1003, 32'h0, 7'h11, 3, 4, 32'hCAFEF00D, 0, 0);
    chk("gm_bp_data", 64'(last_ack_data), 64'hCAFEF00D);
    chk("gm_bp_tag", 64'(last_ack_tag), 64'h11);
    chk("gm_bp_addr", 64'(last_gm_addr), 64'h1000);
    chk("gm_bp_latency", 64'(last_ack_cyc - last_req_cyc), 64'd9);
    do_req(1, 0, 1, 32'h2000, 32'h0, 7'h12, 0, 1, 32'h0BADF00D, 0, 0);
    chk("gm_fast_latency", 64'(last_ack_cyc - last_req_cyc), 64'd3);

    do_req(1, 1, 0, 32'h80, 32'h000055AA, 7'd3, 0, 0, 0, 0, 0);
    chk("both_en_overrun", 64'(bridge_overrun), 64'd1);
    do_req(1, 0, 0, 32'h80, 32'h0, 7'd4, 0, 0, 0, 0, 0);
    chk("both_en_write_won", 64'(last_ack_data), 64'h000055AA);
    a0 = n_acks;
    do_req(0, 1, 1, 32'h3000, 32'h77, 7'd9, 1, 3, 32'h0, 1, 0);
    chk("spur_single_ack", 64'(n_acks - a0), 64'd1);
    chk("overrun_sticky", 64'(bridge_overrun), 64'd1);

    a0 = n_acks;
    do_req(1, 0, 1, 32'h5000, 32'h0, 7'd7, 1, 0, 32'h0, 0, 1);
    repeat (4) @(negedge clk);
    chk("rst_no_ack", 64'(n_acks - a0), 64'd0);
    chk("rst_clears_overrun", 64'(bridge_overrun), 64'd0);
    do_req(1, 0, 0, 32'h40, 32'h0, 7'd8, 0, 0, 0, 0, 0);
    chk("lds_after_rst", 64'(last_ack_data), 64'hA5A50F0F);

`ifdef NEKO_MEM_BRIDGE_TIMEOUT_EN
    a0 = n_acks;
    do_req(1, 0, 1, 32'h6000, 32'h0, 7'h21, -1, -1, 32'h0, 0, 0);
    chk("to_data", 64'(last_ack_data), 64'hDEADBEEF);
    chk("to_latency", 64'(last_ack_cyc - last_req_cyc), 64'(T_TO + 2));
    chk("to_err", 64'(bridge_err), 64'd1);
    do_req(0, 1, 1, 32'h6004, 32'h1, 7'h22, 2, -1, 32'h0, 0, 0);
    repeat (3) @(negedge clk);
    chk("to_single_acks", 64'(n_acks - a0), 64'd2);
`endif

    for (int i = 0; i < 40; i++) begin
      ridx = 12'(32 + $urandom_range(0, 7) * 37);
      ra   = {18'($urandom), ridx, 2'($urandom)};
      rb   = lds_v[ridx] && ($urandom_range(0, 1) == 1);
      wb   = !rb;
      k    = $urandom_range(0, 19);
      if (k == 0) begin rb = 1'b1; wb = 1'b1; end
      do_req(rb, wb, 0, ra, $urandom, 7'($urandom), 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 40; i++) begin
      wb    = ($urandom_range(0, 1) == 1);
      rb    = !wb;
      k     = $urandom_range(0, 19);
      if (k == 0) begin rb = 1'b1; wb = 1'b1; end
      rd_i  = $urandom_range(0, 4);
      rsp_i = $urandom_range(1, 5);
      do_req(rb, wb, 1, $urandom, $urandom, 7'($urandom), rd_i, rsp_i, $urandom, (k == 1), 0);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/neko_lsu_mem_bridge.md
Name: neko_lsu_mem_bridge

Overview:
- Downstream of the LSU op manager: consumes its single-word memory requests (rd/wr enable, addr, wr data, tag, gm_or_lds).
- Steers each request either to an on-chip LDS RAM or to an external global-memory valid/ready port.
- Returns a one-cycle mem_ack pulse with the echoed tag and read data.
- One request in flight at a time. The LSU waits for mem_ack before issuing the next request.

Parameters:
- MEMORY_BUS_WIDTH, 32, data width of the LSU and global-memory data buses.
- LDS_ADDR_WIDTH, 12, LDS word-index width (4096 words).
- GM_TIMEOUT_CYCLES, 255, global-memory watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mem_rd_en  in  1  read request pulse from LSU
- mem_wr_en  in  1  write request pulse from LSU
- mem_gm_or_lds  in  1  1 = global memory, 0 = LDS
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wr_data  in  MEMORY_BUS_WIDTH  write data
- mem_tag_req  in  7  request tag
- mem_ack  out  1  completion pulse to LSU
- mem_tag_resp  out  7  echoed tag, valid with mem_ack
- mem_rd_data  out  MEMORY_BUS_WIDTH  read data, valid with mem_ack
- gm_req_valid  out  1  global-memory request valid
- gm_req_ready  in  1  global-memory request accept
- gm_req_we  out  1  1 = write
- gm_req_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- gm_req_wdata  out  MEMORY_BUS_WIDTH  write data
- gm_resp_valid  in  1  response/write-complete pulse
- gm_resp_rdata  in  MEMORY_BUS_WIDTH  response data
- bridge_busy  out  1  state != IDLE
- bridge_overrun  out  1  sticky protocol-error flag
- bridge_err  out  1  sticky timeout flag

Behaviour:
- Reset (async): state = IDLE; all outputs, latched request registers and sticky flags = 0. LDS RAM contents are not cleared. Reset mid-transaction abandons the transaction; no ack is issued.
- Request capture: in IDLE, if mem_rd_en|mem_wr_en, latch we (=mem_wr_en), addr, wdata, tag and gm_or_lds at the clock edge.
- If both mem_rd_en and mem_wr_en are high: the write wins and bridge_overrun is set.
- Any request arriving while not IDLE is dropped and bridge_overrun is set.
- States:
  - IDLE -> LDS_ACC when the captured request has gm_or_lds = 0.
  - IDLE -> GM_REQ when gm_or_lds = 1.
  - LDS_ACC (1 cycle): RAM read or write at word index addr[LDS_ADDR_WIDTH+1:2]; upper address bits ignored (wrap-around). -> ACK.
  - GM_REQ: gm_req_valid = 1 and req fields held stable until gm_req_ready sampled high. -> GM_WAIT.
  - GM_WAIT: on gm_resp_valid, latch gm_resp_rdata (writes also wait for gm_resp_valid). -> ACK.
  - ACK (1 cycle): mem_ack = 1, mem_tag_resp = tag. mem_rd_data = read data for reads, 0 for writes. -> IDLE.
- Outputs in ACK: mem_ack, mem_tag_resp and mem_rd_data are registered and are 0 outside ACK.
- Latency, request sampled in cycle N:
  - LDS: mem_ack in cycle N+2.
  - GM: mem_ack one cycle after gm_resp_valid is sampled.
- Fastest GM case: gm_req_valid in N+1, ready at N+1, resp at N+2, ack at N+3.
- gm_resp_valid outside GM_WAIT is ignored. The slave must not respond in the handshake cycle.
- Back-to-back: a new request is accepted in the cycle after ACK (IDLE), so LDS throughput is one request per 3 cycles.

Optional Feature:
- Macro NEKO_MEM_BRIDGE_TIMEOUT_EN.
- Enabled:
  - An 8+ bit counter runs in GM_REQ/GM_WAIT and clears on entry to GM_REQ.
  - On reaching GM_TIMEOUT_CYCLES: drop gm_req_valid, go to ACK with mem_rd_data = 32'hDEADBEEF (poison), and set bridge_err.
  - A late gm_resp_valid is ignored.
- Disabled: no counter, the bridge waits indefinitely, bridge_err is tied 0.

Decomposition:
- Package neko_mem_pkg: state encoding (IDLE, LDS_ACC, GM_REQ, GM_WAIT, ACK), GM/LDS select constants (GM = 1'b1, LDS = 1'b0), tag width 7, poison value 32'hDEADBEEF.
- Sub-module neko_lds_ram: single-port synchronous RAM, 2^LDS_ADDR_WIDTH x MEMORY_BUS_WIDTH, one-cycle read latency, write-enable, read-first.

Test Plan:
- LDS write then read: wr addr 0x40, data 0x12345678, tag 5 -> ack at N+2 with tag 5, rd_data 0. Then read 0x40, tag 6 -> ack N+2, rd_data 0x12345678, tag 6.
- LDS wrap: write 0x4000_0040 (LDS_ADDR_WIDTH = 12), read 0x40 -> returns the same data.
- GM read with backpressure: gm_req_ready low 3 cycles, resp 4 cycles later with 0xCAFEF00D, addr 0x1003 -> gm_req_addr 0x1000 held stable, single ack with 0xCAFEF00D and the tag echoed.
- Protocol errors: rd_en+wr_en together -> write performed, overrun = 1. A second request during GM_WAIT -> dropped, only one ack, overrun stays 1 until reset.
- Reset mid-GM_WAIT: assert rst asynchronously -> all outputs 0 immediately, no ack. A following LDS request works normally.
- Timeout (macro on, GM_TIMEOUT_CYCLES = 16): no gm_resp_valid -> ack ~17 cycles after entering GM_REQ with 0xDEADBEEF, bridge_err = 1. A late gm_resp_valid causes no extra ack.
